spill_rate_sequencer: RTL and testbench

//   Per-spill controller for the trigger-rate counter bank.
//   - Detects and debounces the spill "live" gate.
//   - Clears the counters and enables them for the spill.
//   - At end of spill, snapshots all channel counts.
//   - Streams the counts to the readout path over a valid/ready handshake.

---
 rtl/spill_rate_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_spill_rate_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spill_rate_sequencer.sv
// Per-spill controller for the trigger-rate counter bank: debounces the spill gate,
// clears and enables the counters, snapshots them at spill end and streams them out.
module spill_rate_sequencer #(
  parameter int NCH      = 4,
  parameter int CW       = 32,
  parameter int MIN_LIVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              live,
  input  logic [NCH*CW-1:0] cnt_val,
  output logic              cnt_clr,
  output logic              cnt_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_data,
  output logic [3:0]        out_chan,
  output logic              out_last,
  output logic [15:0]       spill_id,
  output logic              busy,
  output logic              ovr,
  input  logic              ovr_clr
);

  localparam int              DW       = (MIN_LIVE > 1) ? $clog2(MIN_LIVE) : 1;
  localparam logic [DW-1:0]   DEB_TOP  = DW'(MIN_LIVE - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NCH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_LATCH = 3'd3,
    ST_SEND  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              live_meta_r;
  logic              live_sync_r;
  logic [DW-1:0]     deb_r;
  logic              level_s;
  logic              deb_hit_s;
  logic              hs_s;
  logic              ovr_set_s;
  logic [3:0]        idx_r;
  logic [3:0]        idx_inc_s;
  logic [NCH*CW-1:0] shadow_r;
  logic              cnt_clr_r;
  logic              cnt_en_r;
  logic              out_valid_r;
  logic [CW-1:0]     out_data_r;
  logic              out_last_r;
  logic [15:0]       spill_id_r;
  logic              busy_r;
  logic              ovr_r;

  // Two-flop synchronizer for the asynchronous spill gate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_meta_r <= 1'b0;
      live_sync_r <= 1'b0;
    end else begin
      live_meta_r <= live;
      live_sync_r <= live_meta_r;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Awaited gate level, edge acceptance and next-state selection
  always_comb begin
    level_s      = 1'b1;
    state_next_s = state_r;
    hs_s         = 1'b0;
    idx_inc_s    = idx_r + 4'd1;

    case (state_r)
      ST_RUN:  level_s = 1'b0;
      default: level_s = 1'b1;
    endcase

    deb_hit_s = (live_sync_r == level_s) && (deb_r == DEB_TOP);
    ovr_set_s = (state_r == ST_SEND) && deb_hit_s;

    case (state_r)
      ST_IDLE: begin
        if (deb_hit_s) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: state_next_s = ST_RUN;
      ST_RUN: begin
        if (deb_hit_s) begin
          state_next_s = ST_LATCH;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_LATCH: state_next_s = ST_SEND;
      ST_SEND: begin
        hs_s = out_valid_r & out_ready;
        if (hs_s && out_last_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SEND;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Debounce counter; saturates so a long high in SEND keeps re-flagging overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_r <= '0;
    end else if (state_next_s != state_r) begin
      deb_r <= '0;
    end else if (live_sync_r != level_s) begin
      deb_r <= '0;
    end else if (deb_r != DEB_TOP) begin
      deb_r <= deb_r + DW'(1);
    end else begin
      deb_r <= deb_r;
    end
  end

  // Control outputs, registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_clr_r   <= 1'b0;
      cnt_en_r    <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      spill_id_r  <= 16'd0;
      ovr_r       <= 1'b0;
    end else begin
      cnt_clr_r   <= (state_next_s == ST_CLEAR);
      cnt_en_r    <= (state_next_s == ST_RUN) & live_meta_r;
      out_valid_r <= (state_next_s == ST_SEND);
      busy_r      <= (state_next_s != ST_IDLE);
      if (state_r == ST_CLEAR) begin
        spill_id_r <= spill_id_r + 16'd1;
      end else begin
        spill_id_r <= spill_id_r;
      end
      if (ovr_set_s) begin
        ovr_r <= 1'b1;
      end else if (ovr_clr) begin
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end
    end
  end

  // Snapshot and readout word; channel 0 comes straight from the counters at LATCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r   <= '0;
      idx_r      <= 4'd0;
      out_data_r <= '0;
      out_last_r <= 1'b0;
    end else begin
      case (state_r)
        ST_LATCH: begin
          shadow_r   <= cnt_val;
          idx_r      <= 4'd0;
          out_data_r <= cnt_val[CW-1:0];
          out_last_r <= (LAST_IDX == 4'd0);
        end
        ST_SEND: begin
          if (hs_s && out_last_r) begin
            idx_r      <= 4'd0;
            out_data_r <= '0;
            out_last_r <= 1'b0;
          end else if (hs_s) begin
            idx_r      <= idx_inc_s;
            out_data_r <= shadow_r[32'(idx_inc_s) * CW +: CW];
            out_last_r <= (idx_inc_s == LAST_IDX);
          end else begin
            idx_r      <= idx_r;
            out_data_r <= out_data_r;
            out_last_r <= out_last_r;
          end
        end
        default: begin
          idx_r      <= idx_r;
          out_data_r <= out_data_r;
          out_last_r <= out_last_r;
        end
      endcase
    end
  end

  assign cnt_clr   = cnt_clr_r;
  assign cnt_en    = cnt_en_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_chan  = idx_r;
  assign out_last  = out_last_r;
  assign spill_id  = spill_id_r;
  assign busy      = busy_r;
  assign ovr       = ovr_r;

endmodule

// File: tb/tb_spill_rate_sequencer.sv
// Bench for spill_rate_sequencer: directed scenarios plus random gate/ready traffic,
// all cycles compared against a timestamp-and-queue reference model.
module tb_spill_rate_sequencer;
  localparam int NCH      = 4;
  localparam int CW       = 32;
  localparam int MIN_LIVE = 4;

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_RUN   = 2;
  localparam int P_LATCH = 3;
  localparam int P_SEND  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              live = 1'b0;
  logic              out_ready = 1'b0;
  logic              ovr_clr = 1'b0;
  logic [NCH*CW-1:0] cnt_val = '0;
  logic              cnt_clr, cnt_en, out_valid, out_last, busy, ovr;
  logic [CW-1:0]     out_data;
  logic [3:0]        out_chan;
  logic [15:0]       spill_id;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_phase;
  bit          m_q1, m_ls, m_ovr;
  int          e = 0;
  int          mis_t;
  logic [15:0] m_sid;
  logic [CW-1:0] m_words[$];

  spill_rate_sequencer #(.NCH(NCH), .CW(CW), .MIN_LIVE(MIN_LIVE)) dut (
    .clk(clk), .rst(rst), .live(live), .cnt_val(cnt_val),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
    .spill_id(spill_id), .busy(busy), .ovr(ovr), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_IDLE;
    m_q1    = 1'b0;
    m_ls    = 1'b0;
    m_ovr   = 1'b0;
    m_sid   = 16'd0;
    mis_t   = e - 1;
    m_words.delete();
  endfunction

  // Advance the model across one rising edge using the inputs present at that edge.
  function automatic void model_edge();
    int lvl;
    int nxt;
    bit acc;
    if (rst) begin
      model_reset();
      mis_t = e;
      e++;
      return;
    end
    lvl = (m_phase == P_RUN) ? 0 : 1;
    if (int'(m_ls) != lvl) mis_t = e;
    acc = (int'(m_ls) == lvl) && (e - mis_t >= MIN_LIVE);
    nxt = m_phase;
    case (m_phase)
      P_IDLE:  if (acc) nxt = P_CLEAR;
      P_CLEAR: begin nxt = P_RUN; m_sid = m_sid + 16'd1; end
      P_RUN:   if (acc) nxt = P_LATCH;
      P_LATCH: begin
        for (int k = 0; k < NCH; k++) m_words.push_back(cnt_val[k*CW +: CW]);
        nxt = P_SEND;
      end
      P_SEND: if (out_ready) begin
        void'(m_words.pop_front());
        if (m_words.size() == 0) nxt = P_IDLE;
      end
      default: nxt = P_IDLE;
    endcase
    if (m_phase == P_SEND && acc) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    if (nxt != m_phase) mis_t = e;
    m_phase = nxt;
    m_ls = m_q1;
    m_q1 = live;
    e++;
  endfunction

  task automatic model_compare();
    check("clr",   32'(cnt_clr),   32'(m_phase == P_CLEAR));
    check("en",    32'(cnt_en),    32'(m_phase == P_RUN && m_ls));
    check("busy",  32'(busy),      32'(m_phase != P_IDLE));
    check("valid", 32'(out_valid), 32'(m_phase == P_SEND));
    check("sid",   32'(spill_id),  32'(m_sid));
    check("ovr",   32'(ovr),       32'(m_ovr));
    if (m_phase == P_SEND && m_words.size() > 0) begin
      check("data", 32'(out_data), 32'(m_words[0]));
      check("chan", 32'(out_chan), 32'(NCH - m_words.size()));
      check("last", 32'(out_last), 32'(m_words.size() == 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_compare();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_sid",   32'(spill_id),  32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    model_compare();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return out_valid;
      1:       return cnt_en;
      2:       return cnt_clr;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int sel, input int limit);
    int n = 0;
    while (!cond(sel) && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(cond(sel)), 32'd1);
  endtask

  initial begin
    int n;
    int remain;
    model_reset();
    @(negedge clk);
    pulse_reset();
    repeat (3) tick();

    // clean rise: clear exactly in cycle 2+MIN_LIVE
    live = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      check("t1_clr", 32'(cnt_clr), 32'(j == 6));
      check("t1_sid", 32'(spill_id), 32'(j >= 7));
      check("t1_en",  32'(cnt_en), 32'(j >= 7));
    end

    // two-cycle low glitch during RUN
    live = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 2) live = 1'b1;
      check("t2_en",    32'(cnt_en), 32'(!(j == 2 || j == 3)));
      check("t2_valid", 32'(out_valid), 32'd0);
    end

    // end of spill, readout with a stall on word 1
    cnt_val = {32'd40, 32'd30, 32'd20, 32'd10};
    out_ready = 1'b1;
    repeat (3) tick();
    live = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("t3_lat", 32'(n), 32'd7);
    check("t3_d0", out_data, 32'd10);
    check("t3_c0", 32'(out_chan), 32'd0);
    tick();
    check("t3_d1", out_data, 32'd20);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      check("t4_hold_d", out_data, 32'd20);
      check("t4_hold_c", 32'(out_chan), 32'd1);
      check("t4_hold_v", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    check("t3_d2", out_data, 32'd30);
    tick();
    check("t3_d3", out_data, 32'd40);
    check("t3_last", 32'(out_last), 32'd1);
    tick();
    check("t3_idle", 32'(busy), 32'd0);

    // overrun: gate re-asserted while SEND is stalled
    live = 1'b1;
    wait_until("t5_run", 1, 20);
    repeat (3) tick();
    out_ready = 1'b0;
    live = 1'b0;
    wait_until("t5_send", 0, 20);
    live = 1'b1;
    repeat (2 + MIN_LIVE + 2) tick();
    check("t5_ovr", 32'(ovr), 32'd1);
    check("t5_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_until("t5_drain", 3, 20);
    wait_until("t5_reclr", 2, 20);
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("t5_clr", 32'(ovr), 32'd0);
    out_ready = 1'b0;
    live = 1'b0;
    wait_until("t5_send2", 0, 20);
    live = 1'b1;
    ovr_clr = 1'b1;
    repeat (2 + MIN_LIVE + 2) tick();
    check("t5_setwins", 32'(ovr), 32'd1);
    ovr_clr = 1'b0;
    out_ready = 1'b1;
    wait_until("t5_drain2", 3, 20);

    // reset mid-RUN, then mid-SEND
    wait_until("t6_run", 1, 20);
    pulse_reset();
    wait_until("t6_clr", 2, 20);
    tick();
    check("t6_sid", 32'(spill_id), 32'd1);
    out_ready = 1'b0;
    live = 1'b0;
    wait_until("t6_send", 0, 20);
    pulse_reset();

    // random traffic against the model
    remain = 0;
    for (int c = 0; c < 4000; c++) begin
      if (remain == 0) begin
        live = ~live;
        remain = $urandom_range(1, 14);
      end
      remain--;
      out_ready = ($urandom_range(0, 3) != 0);
      ovr_clr = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NCH; k++) cnt_val[k*CW +: CW] = $urandom;
      if ($urandom_range(0, 699) == 0) pulse_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
